// File: rtl/cue_pkg.sv
// Shared types and constants for the cue shot controller.
package cue_pkg;

    localparam int unsigned NUM_DIRS = 16;
    localparam int unsigned AIM_W    = 4;
    localparam int unsigned POWER_W  = 6;
    localparam int unsigned VEL_W    = 11;
    localparam int unsigned PROD_W   = 14;

    typedef enum logic [2:0] {
        StIdle,
        StAim,
        StCharge,
        StFire,
        StMoving
    } cue_state_e;

    // round(64*cos(i*22.5 deg))
    localparam logic signed [7:0] COS_LUT [NUM_DIRS] = '{
        8'sd64,  8'sd59,  8'sd45,  8'sd24,  8'sd0,   -8'sd24, -8'sd45, -8'sd59,
        -8'sd64, -8'sd59, -8'sd45, -8'sd24, 8'sd0,   8'sd24,  8'sd45,  8'sd59
    };

    // -round(64*sin(i*22.5 deg)); screen Y grows downward
    localparam logic signed [7:0] NEGSIN_LUT [NUM_DIRS] = '{
        8'sd0,   -8'sd24, -8'sd45, -8'sd59, -8'sd64, -8'sd59, -8'sd45, -8'sd24,
        8'sd0,   8'sd24,  8'sd45,  8'sd59,  8'sd64,  8'sd59,  8'sd45,  8'sd24
    };

    // power * coef at 14-bit signed, arithmetic shift (floor), truncated to VEL_W
    function automatic logic signed [VEL_W-1:0] shot_velocity(
        input logic [POWER_W-1:0] power,
        input logic signed [7:0]  coef,
        input int unsigned        shift
    );
        logic signed [PROD_W-1:0] p_s;
        logic signed [PROD_W-1:0] c_s;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        p_s     = $signed({8'd0, power});
        c_s     = $signed({{6{coef[7]}}, coef});
        prod    = p_s * c_s;
        shifted = prod >>> shift;
        return shifted[VEL_W-1:0];
    endfunction

endpackage

// File: rtl/frame_tick_div.sv
// Counts frame pulses while enabled and emits a one-cycle tick every N frames.
module frame_tick_div #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic en_i,
    input  logic sof_i,
    output logic tick_o
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and tick; disabling clears the count
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (sof_i) begin
            if (cnt_q == CntLast) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Frame count register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cue_shot_ctrl.sv
// Cue ball shot controller: aim, charge, fire a velocity write, wait for the ball to stop.
module cue_shot_ctrl
    import cue_pkg::*;
#(
    parameter int unsigned INITIAL_ANGLE   = 0,
    parameter int unsigned MAX_POWER       = 63,
    parameter int unsigned AIM_FRAMES      = 4,
    parameter int unsigned CHARGE_FRAMES   = 2,
    parameter int unsigned VELOCITY_SHIFT  = 2,
    parameter int unsigned MIN_MOVE_FRAMES = 2
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     ballStopped,
    input  logic                     keyLeft,
    input  logic                     keyRight,
    input  logic                     keyShoot,
    output logic                     velocityWriteEnable,
    output logic signed [VEL_W-1:0]  outVelocityX,
    output logic signed [VEL_W-1:0]  outVelocityY,
    output logic [AIM_W-1:0]         aimAngle,
    output logic [POWER_W-1:0]       shotPower,
    output logic                     cueVisible,
    output logic [7:0]               shotCount
);

    localparam logic [AIM_W-1:0]   InitAim = AIM_W'(INITIAL_ANGLE);
    localparam logic [POWER_W-1:0] MaxPow  = POWER_W'(MAX_POWER);
    localparam logic [7:0]         MinMove = 8'(MIN_MOVE_FRAMES);

    cue_state_e              state_q, state_d;
    logic [AIM_W-1:0]        aim_q, aim_d;
    logic [POWER_W-1:0]      power_q, power_d;
    logic                    vwe_q, vwe_d;
    logic signed [VEL_W-1:0] vx_q, vx_d;
    logic signed [VEL_W-1:0] vy_q, vy_d;
    logic [7:0]              count_q, count_d;
    logic [7:0]              move_q, move_d;
    logic                    cue_q, cue_d;
    logic                    shoot_q;

    logic aim_en, aim_tick;
    logic charge_en, charge_tick;
    logic shoot_rise;

    assign aim_en     = (state_q == StAim) && (keyLeft ^ keyRight);
    assign charge_en  = (state_q == StCharge);
    assign shoot_rise = keyShoot & ~shoot_q;

    frame_tick_div #(
        .N (AIM_FRAMES)
    ) u_aim_div (
        .clk    (clk),
        .resetN (resetN),
        .en_i   (aim_en),
        .sof_i  (startOfFrame),
        .tick_o (aim_tick)
    );

    frame_tick_div #(
        .N (CHARGE_FRAMES)
    ) u_charge_div (
        .clk    (clk),
        .resetN (resetN),
        .en_i   (charge_en),
        .sof_i  (startOfFrame),
        .tick_o (charge_tick)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        aim_d   = aim_q;
        power_d = power_q;
        vwe_d   = 1'b0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        count_d = count_q;
        move_d  = move_q;
        case (state_q)
            StIdle: begin
                if (startOfFrame && ballStopped) state_d = StAim;
            end
            StAim: begin
                if (aim_tick) begin
                    aim_d = keyLeft ? aim_q + AIM_W'(1) : aim_q - AIM_W'(1);
                end
                if (shoot_rise) begin
                    state_d = StCharge;
                    power_d = '0;
                end
            end
            StCharge: begin
                // Release wins over a coincident charge tick
                if (!keyShoot) begin
                    state_d = (power_q != '0) ? StFire : StAim;
                end else if (charge_tick && (power_q < MaxPow)) begin
                    power_d = power_q + POWER_W'(1);
                end
            end
            StFire: begin
                vwe_d   = 1'b1;
                vx_d    = shot_velocity(power_q, COS_LUT[aim_q], VELOCITY_SHIFT);
                vy_d    = shot_velocity(power_q, NEGSIN_LUT[aim_q], VELOCITY_SHIFT);
                count_d = count_q + 8'd1;
                power_d = '0;
                move_d  = '0;
                state_d = StMoving;
            end
            StMoving: begin
                if (startOfFrame) begin
                    if ((move_q >= MinMove) && ballStopped) begin
                        state_d = StAim;
                    end else if (move_q != 8'hFF) begin
                        move_d = move_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        cue_d = (state_d == StAim) || (state_d == StCharge);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            aim_q   <= InitAim;
            power_q <= '0;
            vwe_q   <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            count_q <= '0;
            move_q  <= '0;
            cue_q   <= 1'b0;
            shoot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            aim_q   <= aim_d;
            power_q <= power_d;
            vwe_q   <= vwe_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            count_q <= count_d;
            move_q  <= move_d;
            cue_q   <= cue_d;
            shoot_q <= keyShoot;
        end
    end

    assign velocityWriteEnable = vwe_q;
    assign outVelocityX        = vx_q;
    assign outVelocityY        = vy_q;
    assign aimAngle            = aim_q;
    assign shotPower           = power_q;
    assign cueVisible          = cue_q;
    assign shotCount           = count_q;

endmodule

// File: tb/tb_cue_shot_ctrl.sv
// Self-checking bench for cue_shot_ctrl against a trigonometric reference model.
module tb_cue_shot_ctrl;

    localparam real PI = 3.14159265358979;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               ballStopped;
    logic               keyLeft;
    logic               keyRight;
    logic               keyShoot;
    logic               velocityWriteEnable;
    logic signed [10:0] outVelocityX;
    logic signed [10:0] outVelocityY;
    logic [3:0]         aimAngle;
    logic [5:0]         shotPower;
    logic               cueVisible;
    logic [7:0]         shotCount;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int m_aim    = 0;
    int m_count  = 0;

    cue_shot_ctrl u_dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .ballStopped         (ballStopped),
        .keyLeft             (keyLeft),
        .keyRight            (keyRight),
        .keyShoot            (keyShoot),
        .velocityWriteEnable (velocityWriteEnable),
        .outVelocityX        (outVelocityX),
        .outVelocityY        (outVelocityY),
        .aimAngle            (aimAngle),
        .shotPower           (shotPower),
        .cueVisible          (cueVisible),
        .shotCount           (shotCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts clock cycles during which the strobe is high
    always @(posedge clk) begin
        if (velocityWriteEnable) strobes <= strobes + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    function automatic int rnd(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic int coef_x(input int idx);
        return rnd(64.0 * $cos(real'(idx) * 22.5 * PI / 180.0));
    endfunction

    function automatic int coef_y(input int idx);
        return -rnd(64.0 * $sin(real'(idx) * 22.5 * PI / 180.0));
    endfunction

    // Velocity = floor(power * coef / 4)
    function automatic int exp_vel(input int p, input int c);
        return $rtoi($floor(real'(p * c) / 4.0));
    endfunction

    task automatic set_aim(input int idx);
        int steps;
        steps = (idx - m_aim + 16) % 16;
        keyLeft = 1'b1;
        frames(4 * steps);
        keyLeft = 1'b0;
        tick();
        m_aim = idx;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (velocityWriteEnable !== 1'b0 || outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin
            n_fail++;
            $display("FAIL reset_vel: vwe=%0b x=%0d y=%0d expected 0 0 0",
                     velocityWriteEnable, outVelocityX, outVelocityY);
        end
        n_checks++;
        if (aimAngle !== 4'd0 || shotPower !== 6'd0 || cueVisible !== 1'b0 || shotCount !== 8'd0)
        begin
            n_fail++;
            $display("FAIL reset_state: aim=%0d pow=%0d cue=%0b cnt=%0d expected 0 0 0 0",
                     aimAngle, shotPower, cueVisible, shotCount);
        end
        resetN = 1'b1;
        tick();
        ballStopped = 1'b1;
        frame();
        n_checks++;
        if (cueVisible !== 1'b1 || aimAngle !== 4'd0) begin
            n_fail++;
            $display("FAIL enter_aim: cue=%0b aim=%0d expected 1 0", cueVisible, aimAngle);
        end
        n_checks++;
        if (shotPower !== 6'd0 || shotCount !== 8'd0 || velocityWriteEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_aim_outs: pow=%0d cnt=%0d vwe=%0b expected 0 0 0",
                     shotPower, shotCount, velocityWriteEnable);
        end
        m_aim = 0;
        m_count = 0;
    endtask

    task automatic test_aim();
        int nfr;
        bit left;
        keyRight = 1'b1;
        frames(4);
        keyRight = 1'b0;
        tick();
        m_aim = (m_aim + 15) % 16;
        n_checks++;
        if (aimAngle !== 4'(m_aim)) begin
            n_fail++;
            $display("FAIL aim_right_wrap: aim=%0d expected %0d", aimAngle, m_aim);
        end
        keyLeft = 1'b1;
        keyRight = 1'b1;
        frames(8);
        keyLeft = 1'b0;
        keyRight = 1'b0;
        tick();
        n_checks++;
        if (aimAngle !== 4'(m_aim)) begin
            n_fail++;
            $display("FAIL aim_both_keys: aim=%0d expected %0d", aimAngle, m_aim);
        end
        for (int i = 0; i < 4; i++) begin
            nfr  = $urandom_range(1, 14);
            left = 1'($urandom_range(0, 1));
            keyLeft  = left;
            keyRight = !left;
            frames(nfr);
            keyLeft  = 1'b0;
            keyRight = 1'b0;
            tick();
            m_aim = left ? (m_aim + nfr / 4) % 16 : (m_aim + 16 * 4 - nfr / 4) % 16;
            n_checks++;
            if (aimAngle !== 4'(m_aim)) begin
                n_fail++;
                $display("FAIL aim_random %0d: aim=%0d expected %0d (left=%0b frames=%0d)",
                         i, aimAngle, m_aim, left, nfr);
            end
        end
    endtask

    task automatic test_shot(input int idx, input int pwr, input bit release_on_sof);
        int s0;
        int p_exp;
        logic signed [10:0] ex;
        logic signed [10:0] ey;
        set_aim(idx);
        n_checks++;
        if (aimAngle !== 4'(idx)) begin
            n_fail++;
            $display("FAIL shot_aim idx%0d: aim=%0d expected %0d", idx, aimAngle, idx);
        end
        keyShoot = 1'b1;
        tick();
        frames(2 * pwr + (release_on_sof ? 1 : 0));
        p_exp = (pwr > 63) ? 63 : pwr;
        n_checks++;
        if (shotPower !== 6'(p_exp) || aimAngle !== 4'(idx)) begin
            n_fail++;
            $display("FAIL charge idx%0d: pow=%0d aim=%0d expected %0d %0d",
                     idx, shotPower, aimAngle, p_exp, idx);
        end
        s0 = strobes;
        keyShoot = 1'b0;
        startOfFrame = release_on_sof;
        tick();
        startOfFrame = 1'b0;
        tick();
        ex = 11'(exp_vel(p_exp, coef_x(idx)));
        ey = 11'(exp_vel(p_exp, coef_y(idx)));
        m_count = (m_count + 1) % 256;
        n_checks++;
        if (velocityWriteEnable !== 1'b1 || outVelocityX !== ex || outVelocityY !== ey) begin
            n_fail++;
            $display("FAIL fire idx%0d p%0d: vwe=%0b x=%0d y=%0d expected 1 %0d %0d",
                     idx, p_exp, velocityWriteEnable, outVelocityX, outVelocityY, ex, ey);
        end
        n_checks++;
        if (shotCount !== 8'(m_count) || shotPower !== 6'd0 || cueVisible !== 1'b0) begin
            n_fail++;
            $display("FAIL fire_state idx%0d: cnt=%0d pow=%0d cue=%0b expected %0d 0 0",
                     idx, shotCount, shotPower, cueVisible, m_count);
        end
        tick();
        n_checks++;
        if (velocityWriteEnable !== 1'b0 || outVelocityX !== ex || outVelocityY !== ey) begin
            n_fail++;
            $display("FAIL hold idx%0d: vwe=%0b x=%0d y=%0d expected 0 %0d %0d",
                     idx, velocityWriteEnable, outVelocityX, outVelocityY, ex, ey);
        end
        frames(2);
        n_checks++;
        if (cueVisible !== 1'b0) begin
            n_fail++;
            $display("FAIL moving_min idx%0d: cue=%0b expected 0", idx, cueVisible);
        end
        frame();
        n_checks++;
        if (cueVisible !== 1'b1 || strobes - s0 !== 1) begin
            n_fail++;
            $display("FAIL rearm idx%0d: cue=%0b strobe_cycles=%0d expected 1 1",
                     idx, cueVisible, strobes - s0);
        end
    endtask

    task automatic test_abort();
        int s0;
        s0 = strobes;
        keyShoot = 1'b1;
        tick();
        keyShoot = 1'b0;
        tick();
        repeat (3) tick();
        n_checks++;
        if (strobes !== s0 || shotPower !== 6'd0 || cueVisible !== 1'b1 ||
            shotCount !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL abort: strobes=%0d pow=%0d cue=%0b cnt=%0d expected %0d 0 1 %0d",
                     strobes, shotPower, cueVisible, shotCount, s0, m_count);
        end
    endtask

    task automatic test_shoot_held_moving();
        logic signed [10:0] ex;
        keyShoot = 1'b1;
        tick();
        frames(2);
        keyShoot = 1'b0;
        tick();
        tick();
        m_count = (m_count + 1) % 256;
        keyShoot = 1'b1;
        frames(3);
        frames(4);
        n_checks++;
        if (shotPower !== 6'd0 || cueVisible !== 1'b1) begin
            n_fail++;
            $display("FAIL held_through_moving: pow=%0d cue=%0b expected 0 1",
                     shotPower, cueVisible);
        end
        keyShoot = 1'b0;
        tick();
        keyShoot = 1'b1;
        tick();
        frames(2);
        n_checks++;
        if (shotPower !== 6'd1) begin
            n_fail++;
            $display("FAIL repress_charge: pow=%0d expected 1", shotPower);
        end
        keyShoot = 1'b0;
        tick();
        tick();
        m_count = (m_count + 1) % 256;
        ex = 11'(exp_vel(1, coef_x(m_aim)));
        n_checks++;
        if (velocityWriteEnable !== 1'b1 || outVelocityX !== ex || shotCount !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL repress_fire: vwe=%0b x=%0d cnt=%0d expected 1 %0d %0d",
                     velocityWriteEnable, outVelocityX, shotCount, ex, m_count);
        end
        tick();
        frames(3);
    endtask

    task automatic test_reset_in_charge();
        int s0;
        keyShoot = 1'b1;
        tick();
        frames(10);
        n_checks++;
        if (shotPower !== 6'd5) begin
            n_fail++;
            $display("FAIL pre_reset_charge: pow=%0d expected 5", shotPower);
        end
        s0 = strobes;
        #2;
        resetN = 1'b0;
        #1;
        n_checks++;
        if (shotPower !== 6'd0 || cueVisible !== 1'b0 || shotCount !== 8'd0 ||
            aimAngle !== 4'd0 || velocityWriteEnable !== 1'b0 ||
            outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin
            n_fail++;
            $display("FAIL async_reset: pow=%0d cue=%0b cnt=%0d aim=%0d vwe=%0b x=%0d y=%0d",
                     shotPower, cueVisible, shotCount, aimAngle, velocityWriteEnable,
                     outVelocityX, outVelocityY);
        end
        keyShoot = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
        tick();
        n_checks++;
        if (strobes !== s0 || velocityWriteEnable !== 1'b0 || shotCount !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_no_strobe: strobes=%0d vwe=%0b cnt=%0d expected %0d 0 0",
                     strobes, velocityWriteEnable, shotCount, s0);
        end
        m_aim = 0;
        m_count = 0;
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        ballStopped  = 1'b0;
        keyLeft      = 1'b0;
        keyRight     = 1'b0;
        keyShoot     = 1'b0;
        test_reset();
        test_aim();
        test_shot(0, 10, 1'b0);
        test_shot(2, 10, 1'b0);
        test_shot(4, 63, 1'b0);
        test_shot(6, 70, 1'b0);
        for (int i = 0; i < 3; i++) begin
            test_shot(int'($urandom_range(0, 15)), int'($urandom_range(1, 63)), 1'b0);
        end
        test_shot(int'($urandom_range(0, 15)), int'($urandom_range(1, 40)), 1'b1);
        test_abort();
        test_shoot_held_moving();
        test_reset_in_charge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
